picoblaze_io_hub: RTL and testbench

Parametrised I/O and interrupt front end for the pacoblaze3 soft core. It generalises the single-input, single-interrupt, two-LED-port wrapper to NUM_IN input channels and NUM_OUT output registers. Each input channel latches its data and raises its own pending flag, and a priority interrupt controller drives the core's interrupt line. The block sits between the core (port_id/in_port/out_port/strobes/interrupt) and application logic such as the audio/LED datapath.

---
 rtl/picoblaze_io_pkg.sv | 18 +
 rtl/picoblaze_irq_ctrl.sv | 84 ++++++++
 rtl/picoblaze_io_hub.sv | 87 ++++++++
 tb/tb_picoblaze_io_hub.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/picoblaze_io_pkg.sv
// Shared port map, vector constants and interrupt FSM states for the
// pacoblaze3 I/O and interrupt front end.
package picoblaze_io_pkg;

  localparam logic [7:0] PORT_DATA_BASE = 8'h00;
  localparam logic [7:0] PORT_PENDING   = 8'h10;
  localparam logic [7:0] PORT_OVERRUN   = 8'h11;
  localparam logic [7:0] PORT_ENABLE    = 8'h12;
  localparam logic [7:0] PORT_VECTOR    = 8'h13;
  localparam logic [7:0] PORT_OUT_BASE  = 8'h20;
  localparam logic [7:0] PORT_ENABLE_WR = 8'h30;
  localparam logic [7:0] PORT_CLEAR     = 8'h31;

  localparam logic [7:0] NO_VECTOR = 8'hFF;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t;

endpackage

// File: rtl/picoblaze_irq_ctrl.sv
// Per-channel pending/overrun/enable flags, lowest-index priority encoder
// and the request/acknowledge/service FSM driving the core's interrupt.
module picoblaze_irq_ctrl #(
  parameter int NUM_IN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_IN-1:0] in_ready,
  input  logic              enable_wr,
  input  logic              clear_wr,
  input  logic [NUM_IN-1:0] wr_data,
  input  logic              interrupt_ack,
  output logic [NUM_IN-1:0] pending,
  output logic [NUM_IN-1:0] overrun,
  output logic [NUM_IN-1:0] enable,
  output logic [7:0]        vector,
  output logic              interrupt,
  output logic              overrun_any
);
  import picoblaze_io_pkg::*;

  logic [NUM_IN-1:0] active;
  logic [NUM_IN-1:0] pending_d;
  logic [NUM_IN-1:0] overrun_d;
  irq_state_t        state, state_d;

  assign active    = pending & enable;
  assign interrupt = (state == REQ);

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    vector = NO_VECTOR;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (active[i]) vector = 8'(i);
    end
  end

  // A new event beats a simultaneous clear; that clear still consumes the
  // earlier event, so overrun only survives when no clear hit the bit.
  always_comb begin
    pending_d = pending;
    overrun_d = overrun;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_ready[i]) begin
        pending_d[i] = 1'b1;
        overrun_d[i] = (clear_wr && wr_data[i]) ? 1'b0 : (pending[i] | overrun[i]);
      end else if (clear_wr && wr_data[i]) begin
        pending_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (|active) state_d = REQ;
      REQ:     if (interrupt_ack) state_d = SERVICE;
               else if (!(|active)) state_d = IDLE;
      SERVICE: if (clear_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= '0;
      overrun     <= '0;
      enable      <= '1;
      overrun_any <= 1'b0;
      state       <= IDLE;
    end else begin
      pending     <= pending_d;
      overrun     <= overrun_d;
      overrun_any <= |overrun_d;
      state       <= state_d;
      if (enable_wr) enable <= wr_data;
    end
  end

endmodule

// File: rtl/picoblaze_io_hub.sv
// pacoblaze3 I/O hub: latches NUM_IN input channels, serves a registered read
// map, holds NUM_OUT output registers and fronts the interrupt controller.
module picoblaze_io_hub #(
  parameter int         NUM_IN    = 4,
  parameter int         NUM_OUT   = 2,
  parameter logic [7:0] OUT_RESET = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [8*NUM_IN-1:0]  in_data,
  input  logic [NUM_IN-1:0]    in_ready,
  input  logic [7:0]           port_id,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  input  logic [7:0]           out_port,
  output logic [7:0]           in_port,
  output logic                 interrupt,
  input  logic                 interrupt_ack,
  output logic [8*NUM_OUT-1:0] out_regs,
  output logic                 overrun_any
);
  import picoblaze_io_pkg::*;

  logic [7:0]        hold [NUM_IN];
  logic [NUM_IN-1:0] pending, overrun, enable;
  logic [7:0]        vector;
  logic [7:0]        rd_data;
  logic              enable_wr, clear_wr;

  // Reads carry no side effects, so the read qualifier is not needed.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  assign enable_wr = write_strobe && (port_id == PORT_ENABLE_WR);
  assign clear_wr  = write_strobe && (port_id == PORT_CLEAR);

  picoblaze_irq_ctrl #(.NUM_IN(NUM_IN)) u_irq_ctrl (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_ready      (in_ready),
    .enable_wr     (enable_wr),
    .clear_wr      (clear_wr),
    .wr_data       (out_port[NUM_IN-1:0]),
    .interrupt_ack (interrupt_ack),
    .pending       (pending),
    .overrun       (overrun),
    .enable        (enable),
    .vector        (vector),
    .interrupt     (interrupt),
    .overrun_any   (overrun_any)
  );

  always_comb begin
    rd_data = '0;
    case (port_id)
      PORT_PENDING: rd_data[NUM_IN-1:0] = pending;
      PORT_OVERRUN: rd_data[NUM_IN-1:0] = overrun;
      PORT_ENABLE:  rd_data[NUM_IN-1:0] = enable;
      PORT_VECTOR:  rd_data = vector;
      default: begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (port_id == PORT_DATA_BASE + 8'(i)) rd_data = hold[i];
        end
      end
    endcase
  end

  // NOTE: the hold bytes are a small register array, not a RAM, so they take
  // the async reset to give the core defined read data right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IN; i++) hold[i] <= '0;
      in_port  <= '0;
      out_regs <= {NUM_OUT{OUT_RESET}};
    end else begin
      in_port <= rd_data;
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_ready[i]) hold[i] <= in_data[8*i +: 8];
      end
      for (int j = 0; j < NUM_OUT; j++) begin
        if (write_strobe && port_id == PORT_OUT_BASE + 8'(j))
          out_regs[8*j +: 8] <= out_port;
      end
    end
  end

endmodule

// File: tb/tb_picoblaze_io_hub.sv
// Directed bench for picoblaze_io_hub (NUM_IN=4, NUM_OUT=2): reset values,
// events, priority, overrun, masking, collisions, outputs and async reset.
module tb_picoblaze_io_hub;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [7:0]  port_id;
  logic        write_strobe;
  logic        read_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack;
  logic [15:0] out_regs;
  logic        overrun_any;

  int n_checks = 0;
  int n_pass   = 0;

  picoblaze_io_hub #(.NUM_IN(4), .NUM_OUT(2), .OUT_RESET(8'h00)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .out_regs      (out_regs),
    .overrun_any   (overrun_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Advance one edge and settle 1 ns past it; inputs change and outputs are
  // sampled at this point, well away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    port_id     = addr;
    read_strobe = 1'b1;
    step();
    read_strobe = 1'b0;
    check(tag, {24'h0, in_port}, {24'h0, exp});
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
    port_id      = 8'hEE;
  endtask

  task automatic strobe(input logic [3:0] mask);
    in_ready = mask;
    step();
    in_ready = '0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_data = '0; in_ready = '0; port_id = 8'hEE;
    write_strobe = 1'b0; read_strobe = 1'b0; out_port = '0; interrupt_ack = 1'b0;

    // Reset values
    #23;
    check("rst_out_regs", {16'h0, out_regs}, 32'h0);
    check("rst_interrupt", {31'h0, interrupt}, 32'h0);
    check("rst_in_port", {24'h0, in_port}, 32'h0);
    check("rst_overrun_any", {31'h0, overrun_any}, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    rd("rst_enable", 8'h12, 8'h0F);
    rd("rst_vector", 8'h13, 8'hFF);
    rd("rst_pending", 8'h10, 8'h00);
    rd("unmapped_read", 8'h55, 8'h00);

    // Single event on channel 2
    in_data[23:16] = 8'hA5;
    strobe(4'b0100);
    step();
    check("ev_irq_set", {31'h0, interrupt}, 32'h1);
    rd("ev_vector", 8'h13, 8'h02);
    rd("ev_hold2", 8'h02, 8'hA5);
    ack();
    check("ev_irq_after_ack", {31'h0, interrupt}, 32'h0);
    wr(8'h31, 8'h04);
    rd("ev_pending_clr", 8'h10, 8'h00);
    check("ev_irq_stays_low", {31'h0, interrupt}, 32'h0);

    // Priority and re-arm
    in_data[15:8]  = 8'h11;
    in_data[31:24] = 8'h33;
    strobe(4'b1010);
    step();
    check("pri_irq", {31'h0, interrupt}, 32'h1);
    rd("pri_vector_ch1", 8'h13, 8'h01);
    ack();
    wr(8'h31, 8'h02);
    check("pri_irq_dropped", {31'h0, interrupt}, 32'h0);
    step();
    check("pri_irq_rearm", {31'h0, interrupt}, 32'h1);
    rd("pri_vector_ch3", 8'h13, 8'h03);
    ack();
    wr(8'h31, 8'h08);
    step();
    check("pri_idle", {31'h0, interrupt}, 32'h0);

    // Overrun on channel 0
    in_data[7:0] = 8'h11;
    strobe(4'b0001);
    in_data[7:0] = 8'h22;
    strobe(4'b0001);
    rd("ovr_hold0", 8'h00, 8'h22);
    rd("ovr_flags", 8'h11, 8'h01);
    check("ovr_any_set", {31'h0, overrun_any}, 32'h1);
    wr(8'h31, 8'h01);
    rd("ovr_pending_clr", 8'h10, 8'h00);
    rd("ovr_flags_clr", 8'h11, 8'h00);
    check("ovr_any_clr", {31'h0, overrun_any}, 32'h0);
    step();
    check("ovr_irq_withdrawn", {31'h0, interrupt}, 32'h0);

    // Masking and set/clear collision
    wr(8'h30, 8'h00);
    in_data[7:0] = 8'h66;
    strobe(4'b0001);
    step();
    rd("mask_pending", 8'h10, 8'h01);
    check("mask_irq_low", {31'h0, interrupt}, 32'h0);
    wr(8'h30, 8'h01);
    step();
    check("unmask_irq", {31'h0, interrupt}, 32'h1);
    in_data[7:0] = 8'h77;
    in_ready     = 4'b0001;
    wr(8'h31, 8'h01);
    in_ready     = '0;
    rd("coll_pending", 8'h10, 8'h01);
    rd("coll_overrun", 8'h11, 8'h00);
    rd("coll_hold0", 8'h00, 8'h77);

    // Output registers
    wr(8'h21, 8'h5A);
    check("out_reg1", {16'h0, out_regs}, 32'h5A00);
    wr(8'h22, 8'hFF);
    check("out_beyond_ignored", {16'h0, out_regs}, 32'h5A00);
    wr(8'h20, 8'h3C);
    check("out_reg0", {16'h0, out_regs}, 32'h5A3C);

    // Async reset while requesting
    check("pre_reset_irq", {31'h0, interrupt}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", {31'h0, interrupt}, 32'h0);
    check("async_rst_out", {16'h0, out_regs}, 32'h0);
    #3;
    reset_n = 1'b1;
    step();
    rd("post_rst_pending", 8'h10, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
